linproj_tile_sequencer: RTL
===========================

// Module: linproj_tile_sequencer
// PURPOSE
//  Runtime-configurable tile scheduler for the Q/K/V linear projection. Walks every output block
//  (ROW_SIZE_MAT_C x COL_SIZE_MAT_C) and, per tile, every inner block, issuing paired A/B
//  read addresses to the multi_matmul datapath over a valid/ready handshake. Adds weight-key
//  select (Q1..Qn in one B memory), row- or column-major tile order, and accumulate-done pacing.
// PARAMETERS
//  A_OUTER_DIMENSION     16  rows of input matrix A
//  B_OUTER_DIMENSION     16  columns of output (rows of weight B, transposed storage)
//  INNER_DIMENSION        6  shared dimension
//  BLOCK_SIZE             2  systolic block edge
//  NUM_CORES_A            2  cores consuming A per module
//  NUM_CORES_B            1  cores consuming B per module
//  TOTAL_MODULES          4  matmul modules in parallel
//  TOTAL_INPUT_W          2  A input ports
//  TOTAL_WEIGHT_PER_KEY   4  weight sets stored back-to-back in B memory
//  derived: IB=INNER_DIMENSION/BLOCK_SIZE; ROWS=A_OUTER/(BLOCK*NUM_CORES_A*TOTAL_INPUT_W);
//   COLS=B_OUTER/(BLOCK*NUM_CORES_B*TOTAL_MODULES); MAX_FLAG=ROWS*COLS;
//   ADDR_WIDTH_A=max(1,$clog2(ROWS*IB)); ADDR_WIDTH_B=max(1,$clog2(TOTAL_WEIGHT_PER_KEY*COLS*IB))
// PORTS
//  clk         in   1                      clock
//  rst         in   1                      async active-high reset
//  start       in   1                      begin run (sampled in IDLE only)
//  key_sel     in   $clog2(TWPK) (min 1)   weight set index, latched on accepted start
//  col_major   in   1                      0: c inner loop; 1: r inner loop; latched on start
//  busy        out  1                      high from accepted start until done cycle inclusive
//  cfg_err     out  1                      1-cycle pulse: start rejected (key_sel>=TWPK)
//  addr_valid  out  1                      addr_a/addr_b/flags valid
//  addr_ready  in   1                      datapath accepts current address pair
//  addr_a      out  ADDR_WIDTH_A           = r*IB + k
//  addr_b      out  ADDR_WIDTH_B           = key*COLS*IB + c*IB + k
//  first_k     out  1                      k==0 (datapath clears accumulator)
//  last_k      out  1                      k==IB-1
//  tile_row    out  $clog2(ROWS) (min 1)   current r
//  tile_col    out  $clog2(COLS) (min 1)   current c
//  acc_done    in   1                      datapath finished writing current tile
//  tile_done   out  1                      1-cycle pulse per completed tile
//  done        out  1                      1-cycle pulse after final tile
// BEHAVIOUR
//  - Reset: state IDLE, r=c=k=0, all outputs 0 (addresses 0).
//  - FSM IDLE->RUN->WAIT_ACC->(RUN|DONE)->IDLE, all outputs registered.
//  - IDLE: start & key_sel<TWPK -> RUN next cycle, busy=1, addr_valid=1 with r=c=k=0.
//    start & key_sel>=TWPK -> stay IDLE, cfg_err=1 next cycle.
//  - RUN: addr_valid held until valid&ready; outputs stable while stalled. Each transfer k++.
//    Transfer with last_k -> WAIT_ACC, addr_valid=0 next cycle. Back-to-back transfers at 1/clk.
//  - WAIT_ACC: wait for acc_done; on it, tile_done=1 next cycle and tile advances:
//    row-major c++ (wrap c->0, r++); col-major r++ (wrap r->0, c++). k=0.
//    Last tile (r=ROWS-1,c=COLS-1) -> DONE; else RUN with addr_valid=1 same cycle as tile_done.
//  - DONE: done=1 and busy=1 for one cycle -> IDLE (busy=0).
//  - acc_done outside WAIT_ACC and start while busy are ignored (no error).
//  - IB=1: every transfer has first_k=last_k=1. ROWS=COLS=1: one tile, then DONE.
//  - Async reset mid-run returns to IDLE immediately; no done/tile_done emitted.
//  - Total handshakes per run = MAX_FLAG*IB; key offset computed once at start (no multiplier
//    in loop path; COLS*IB constant).
// TESTING
//  1. Defaults, key_sel=1, row-major, ready=1, acc_done 3 cyc after last_k -> tiles (0,0),(0,1),
//     (1,0),(1,1); addr_a {0,1,2},{0,1,2},{3,4,5},{3,4,5}; addr_b {6,7,8},{9,10,11},{6,7,8},{9,10,11}.
//  2. Same, col_major=1 -> tile order (0,0),(1,0),(0,1),(1,1); 12 handshakes, 4 tile_done, 1 done.
//  3. addr_ready toggled randomly -> no address skipped/repeated; outputs stable during stall.
//  4. key_sel=3 -> addr_b base 18 (max 23); key_sel out of range only if TWPK not power of 2
//     (run with TWPK=3, key_sel=3) -> cfg_err pulse, busy stays 0.
//  5. rst asserted during WAIT_ACC of tile 2 -> all outputs 0 at once; new start replays from (0,0).
//  6. acc_done pulsed in RUN and start pulsed mid-run -> ignored; sequence identical to test 1.

Source files
------------

// File: rtl/linproj_tile_sequencer_if.sv
// Address-issue channel between the tile sequencer and the matmul datapath.
interface linproj_tile_sequencer_if #(
  parameter int unsigned AddrWidthA = 3,
  parameter int unsigned AddrWidthB = 5,
  parameter int unsigned RowWidth   = 1,
  parameter int unsigned ColWidth   = 1
);
  logic                  addr_valid;
  logic                  addr_ready;
  logic [AddrWidthA-1:0] addr_a;
  logic [AddrWidthB-1:0] addr_b;
  logic                  first_k;
  logic                  last_k;
  logic [RowWidth-1:0]   tile_row;
  logic [ColWidth-1:0]   tile_col;
  logic                  acc_done;
  logic                  tile_done;

  modport master (
    output addr_valid, addr_a, addr_b, first_k, last_k, tile_row, tile_col, tile_done,
    input  addr_ready, acc_done
  );

  modport slave (
    input  addr_valid, addr_a, addr_b, first_k, last_k, tile_row, tile_col, tile_done,
    output addr_ready, acc_done
  );
endinterface

// File: rtl/linproj_tile_sequencer.sv
// Tile scheduler for the Q/K/V projection: walks output tiles and inner blocks, issuing paired
// A/B read addresses with weight-key offset, selectable tile order and accumulate-done pacing.
module linproj_tile_sequencer #(
  parameter int unsigned A_OUTER_DIMENSION    = 16,
  parameter int unsigned B_OUTER_DIMENSION    = 16,
  parameter int unsigned INNER_DIMENSION      = 6,
  parameter int unsigned BLOCK_SIZE           = 2,
  parameter int unsigned NUM_CORES_A          = 2,
  parameter int unsigned NUM_CORES_B          = 1,
  parameter int unsigned TOTAL_MODULES        = 4,
  parameter int unsigned TOTAL_INPUT_W        = 2,
  parameter int unsigned TOTAL_WEIGHT_PER_KEY = 4,
  localparam int unsigned KeyW = (TOTAL_WEIGHT_PER_KEY > 1) ? $clog2(TOTAL_WEIGHT_PER_KEY) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [KeyW-1:0] key_sel_i,
  input  logic            col_major_i,
  output logic            busy_o,
  output logic            cfg_err_o,
  output logic            done_o,
  linproj_tile_sequencer_if.master seq_if
);

  localparam int unsigned IB   = INNER_DIMENSION / BLOCK_SIZE;
  localparam int unsigned Rows = A_OUTER_DIMENSION / (BLOCK_SIZE * NUM_CORES_A * TOTAL_INPUT_W);
  localparam int unsigned Cols = B_OUTER_DIMENSION / (BLOCK_SIZE * NUM_CORES_B * TOTAL_MODULES);
  localparam int unsigned KeyStride  = Cols * IB;
  localparam int unsigned AddrWidthA = (Rows * IB > 1) ? $clog2(Rows * IB) : 1;
  localparam int unsigned AddrWidthB =
      (TOTAL_WEIGHT_PER_KEY * KeyStride > 1) ? $clog2(TOTAL_WEIGHT_PER_KEY * KeyStride) : 1;
  localparam int unsigned RowWidth = (Rows > 1) ? $clog2(Rows) : 1;
  localparam int unsigned ColWidth = (Cols > 1) ? $clog2(Cols) : 1;
  localparam int unsigned KWidth   = (IB > 1) ? $clog2(IB) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StWaitAcc, StDone} state_e;

  state_e                state_q, state_d;
  logic [RowWidth-1:0]   r_q, r_d;
  logic [ColWidth-1:0]   c_q, c_d;
  logic [KWidth-1:0]     k_q, k_d;
  logic [AddrWidthA-1:0] row_base_q, row_base_d, addr_a_q, addr_a_d;
  logic [AddrWidthB-1:0] key_base_q, key_base_d, col_base_q, col_base_d, addr_b_q, addr_b_d;
  logic                  valid_q, valid_d, first_k_q, first_k_d, last_k_q, last_k_d;
  logic                  tile_done_q, tile_done_d, done_q, done_d, cfg_err_q, cfg_err_d;
  logic                  busy_q, busy_d, col_major_q, col_major_d;

  logic                  key_ok, last_row, last_col;
  logic [AddrWidthB-1:0] start_base;

  assign key_ok   = {1'b0, key_sel_i} < (KeyW + 1)'(TOTAL_WEIGHT_PER_KEY);
  assign last_row = r_q == RowWidth'(Rows - 1);
  assign last_col = c_q == ColWidth'(Cols - 1);
  // Only multiply in the design; evaluated once when a run is accepted.
  assign start_base = AddrWidthB'(key_sel_i) * AddrWidthB'(KeyStride);

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    c_d         = c_q;
    k_d         = k_q;
    row_base_d  = row_base_q;
    key_base_d  = key_base_q;
    col_base_d  = col_base_q;
    addr_a_d    = addr_a_q;
    addr_b_d    = addr_b_q;
    valid_d     = valid_q;
    first_k_d   = first_k_q;
    last_k_d    = last_k_q;
    busy_d      = busy_q;
    col_major_d = col_major_q;
    tile_done_d = 1'b0;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (start_i) begin
          if (key_ok) begin
            state_d     = StRun;
            busy_d      = 1'b1;
            valid_d     = 1'b1;
            col_major_d = col_major_i;
            r_d         = '0;
            c_d         = '0;
            k_d         = '0;
            row_base_d  = '0;
            key_base_d  = start_base;
            col_base_d  = start_base;
            addr_a_d    = '0;
            addr_b_d    = start_base;
            first_k_d   = 1'b1;
            last_k_d    = (IB == 1);
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      StRun: begin
        if (valid_q && seq_if.addr_ready) begin
          if (last_k_q) begin
            state_d = StWaitAcc;
            valid_d = 1'b0;
          end else begin
            k_d       = k_q + KWidth'(1);
            addr_a_d  = addr_a_q + AddrWidthA'(1);
            addr_b_d  = addr_b_q + AddrWidthB'(1);
            first_k_d = 1'b0;
            last_k_d  = (k_q + KWidth'(1)) == KWidth'(IB - 1);
          end
        end
      end

      StWaitAcc: begin
        if (seq_if.acc_done) begin
          tile_done_d = 1'b1;
          if (last_row && last_col) begin
            state_d = StDone;
          end else begin
            // Bases step by IB so the loop path needs only adders.
            if (!col_major_q) begin
              if (last_col) begin
                c_d        = '0;
                col_base_d = key_base_q;
                r_d        = r_q + RowWidth'(1);
                row_base_d = row_base_q + AddrWidthA'(IB);
              end else begin
                c_d        = c_q + ColWidth'(1);
                col_base_d = col_base_q + AddrWidthB'(IB);
              end
            end else begin
              if (last_row) begin
                r_d        = '0;
                row_base_d = '0;
                c_d        = c_q + ColWidth'(1);
                col_base_d = col_base_q + AddrWidthB'(IB);
              end else begin
                r_d        = r_q + RowWidth'(1);
                row_base_d = row_base_q + AddrWidthA'(IB);
              end
            end
            state_d   = StRun;
            valid_d   = 1'b1;
            k_d       = '0;
            addr_a_d  = row_base_d;
            addr_b_d  = col_base_d;
            first_k_d = 1'b1;
            last_k_d  = (IB == 1);
          end
        end
      end

      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      r_q         <= '0;
      c_q         <= '0;
      k_q         <= '0;
      row_base_q  <= '0;
      key_base_q  <= '0;
      col_base_q  <= '0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      valid_q     <= 1'b0;
      first_k_q   <= 1'b0;
      last_k_q    <= 1'b0;
      tile_done_q <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      col_major_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      c_q         <= c_d;
      k_q         <= k_d;
      row_base_q  <= row_base_d;
      key_base_q  <= key_base_d;
      col_base_q  <= col_base_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
      valid_q     <= valid_d;
      first_k_q   <= first_k_d;
      last_k_q    <= last_k_d;
      tile_done_q <= tile_done_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
      busy_q      <= busy_d;
      col_major_q <= col_major_d;
    end
  end

  assign busy_o           = busy_q;
  assign cfg_err_o        = cfg_err_q;
  assign done_o           = done_q;
  assign seq_if.addr_valid = valid_q;
  assign seq_if.addr_a     = addr_a_q;
  assign seq_if.addr_b     = addr_b_q;
  assign seq_if.first_k    = first_k_q;
  assign seq_if.last_k     = last_k_q;
  assign seq_if.tile_row   = r_q;
  assign seq_if.tile_col   = c_q;
  assign seq_if.tile_done  = tile_done_q;

endmodule
